// File: rtl/mux_tree_pipe_if.sv
// Handshake/data bundle for mux_tree_pipe: N channels of W bits in, one W-bit channel out.
// sel_err is present only when SEL_RANGE_CHECK_EN is defined.
interface mux_tree_pipe_if #(
    parameter int N  = 12,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [SW-1:0]  in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
`ifdef SEL_RANGE_CHECK_EN
    logic           sel_err;

    modport master (output in_data, in_sel, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, sel_err);
    modport slave  (input  in_data, in_sel, in_valid, out_ready,
                    output in_ready, out_data, out_valid, sel_err);
`else
    modport master (output in_data, in_sel, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_data, in_sel, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N:1 W-bit selector built as a registered binary tree of 2:1 stages with valid/ready.
// Define SEL_RANGE_CHECK_EN to add a pipelined out-of-range select flag (sel_err).
module mux_tree_pipe #(
    parameter int N  = 12,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_tree_pipe_if.slave bus
);
    localparam int L = SW;
    localparam int P = 1 << L;

    logic stall_s;

    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int CH = P >> k;

        logic [CH*W-1:0] data_s;
        logic            valid_s;
`ifdef SEL_RANGE_CHECK_EN
        logic            err_s;
`endif

        // Select bits not yet consumed travel with the request; the last level needs none.
        if (k < L) begin : g_sel
            logic [L-k-1:0] sel_s;
            if (k == 0) begin : g_src
                assign sel_s = bus.in_sel;
            end else begin : g_reg
                logic [L-k-1:0] sel_d;
                logic [L-k-1:0] sel_q;

                // Next select state: drop the bit used at this level, or hold on stall.
                always_comb begin
                    sel_d = sel_q;
                    if (stall_s) begin
                        sel_d = sel_q;
                    end else begin
                        sel_d = g_lvl[k-1].g_sel.sel_s[L-k:1];
                    end
                end

                // Select-bit stage register.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        sel_q <= {(L-k){1'b0}};
                    end else begin
                        sel_q <= sel_d;
                    end
                end

                assign sel_s = sel_q;
            end
        end

        if (k == 0) begin : g_in
            // Zero-padding to 2^L channels makes out-of-range selects return 0.
            assign data_s  = (CH*W)'(bus.in_data);
            assign valid_s = bus.in_valid;
`ifdef SEL_RANGE_CHECK_EN
            assign err_s   = (32'(bus.in_sel) >= 32'(N));
`endif
        end else begin : g_stage
            logic [CH*W-1:0] data_d;
            logic [CH*W-1:0] data_q;
            logic            valid_d;
            logic            valid_q;
            logic            sel_bit_s;
`ifdef SEL_RANGE_CHECK_EN
            logic            err_d;
            logic            err_q;
`endif

            assign sel_bit_s = g_lvl[k-1].g_sel.sel_s[0];

            // Pairwise 2:1 reduction of the previous level; whole pipe freezes on stall.
            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
`ifdef SEL_RANGE_CHECK_EN
                err_d   = err_q;
`endif
                if (stall_s) begin
                    data_d  = data_q;
                    valid_d = valid_q;
                end else begin
                    for (int j = 0; j < CH; j++) begin
                        if (sel_bit_s) begin
                            data_d[j*W +: W] = g_lvl[k-1].data_s[(2*j+1)*W +: W];
                        end else begin
                            data_d[j*W +: W] = g_lvl[k-1].data_s[(2*j)*W +: W];
                        end
                    end
                    valid_d = g_lvl[k-1].valid_s;
`ifdef SEL_RANGE_CHECK_EN
                    err_d   = g_lvl[k-1].err_s;
`endif
                end
            end

            // Data/valid stage register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q  <= {(CH*W){1'b0}};
                    valid_q <= 1'b0;
`ifdef SEL_RANGE_CHECK_EN
                    err_q   <= 1'b0;
`endif
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
`ifdef SEL_RANGE_CHECK_EN
                    err_q   <= err_d;
`endif
                end
            end

            assign data_s  = data_q;
            assign valid_s = valid_q;
`ifdef SEL_RANGE_CHECK_EN
            assign err_s   = err_q;
`endif
        end
    end

    assign stall_s       = g_lvl[L].valid_s && !bus.out_ready;
    assign bus.in_ready  = !stall_s;
    assign bus.out_data  = g_lvl[L].data_s;
    assign bus.out_valid = g_lvl[L].valid_s;
`ifdef SEL_RANGE_CHECK_EN
    assign bus.sel_err   = g_lvl[L].err_s && g_lvl[L].valid_s;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: N=12/W=8 main instance plus an N=2/W=1 corner instance.
module tb_mux_tree_pipe;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mux_tree_pipe_if #(.N(12), .W(8)) bus  ();
    mux_tree_pipe_if #(.N(2),  .W(1)) bus2 ();

    mux_tree_pipe #(.N(12), .W(8)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    mux_tree_pipe #(.N(2),  .W(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   nxt_in;
        int   nxt_out;
        int   stall_left;
        bit   seen;
        logic exp_v;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 4'd0;
        bus.out_ready  = 1'b1;
        for (int c = 0; c < 12; c++) bus.in_data[c*8 +: 8] = 8'h10 + 8'(c);
        bus2.in_data   = 2'b10;
        bus2.in_sel    = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst2_out_valid", 32'(bus2.out_valid), 32'd0);
        rst_n = 1'b1;

        // sel 0,5,11 back to back; outputs on cycles 4,5,6
        bus.in_valid = 1'b1; bus.in_sel = 4'd0;
        tick();
        chk("seq_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_sel = 4'd5;
        tick();
        bus.in_sel = 4'd11;
        tick();
        bus.in_valid = 1'b0;
        chk("seq_c3_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("seq_c4_valid", 32'(bus.out_valid), 32'd1);
        chk("seq_c4_data",  32'(bus.out_data),  32'h10);
        tick();
        chk("seq_c5_data",  32'(bus.out_data),  32'h15);
        chk("seq_c5_ready", 32'(bus.in_ready),  32'd1);
        tick();
        chk("seq_c6_data",  32'(bus.out_data),  32'h1b);
        tick();
        chk("seq_c7_valid", 32'(bus.out_valid), 32'd0);

        // stream 0..11 with a 3-cycle stall at the first output
        nxt_in = 0; nxt_out = 0; stall_left = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 3;
            end
            bus.out_ready = (stall_left == 0);
            bus.in_valid  = (nxt_in < 12);
            bus.in_sel    = 4'(nxt_in);
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
                chk("stall_valid",    32'(bus.out_valid), 32'd1);
                chk("stall_data",     32'(bus.out_data),  32'h10);
                stall_left--;
            end else begin
                chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
                if (bus.out_valid) begin
                    chk("stream_data", 32'(bus.out_data), 32'h10 + 32'(nxt_out));
                    nxt_out++;
                end
                if (bus.in_valid) nxt_in++;
            end
            tick();
        end
        chk("stream_out_count", 32'(nxt_out), 32'd12);
        chk("stream_stalled",   32'(seen),    32'd1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;

        // alternating valid with sel=3: bubbles preserved
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = (i < 6) && (i % 2 == 0);
            bus.in_sel   = 4'd3;
            exp_v = (i >= 4) && (i - 4 < 6) && ((i - 4) % 2 == 0);
            chk("bubble_valid", 32'(bus.out_valid), 32'(exp_v));
            if (exp_v) chk("bubble_data", 32'(bus.out_data), 32'h13);
            tick();
        end
        bus.in_valid = 1'b0;

        // out-of-range select 13, then sel 2
        bus.in_valid = 1'b1; bus.in_sel = 4'd13;
        tick();
        bus.in_sel = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("oor_valid", 32'(bus.out_valid), 32'd1);
        chk("oor_data",  32'(bus.out_data),  32'd0);
`ifdef SEL_RANGE_CHECK_EN
        chk("oor_sel_err", 32'(bus.sel_err), 32'd1);
`endif
        tick();
        chk("after_oor_data", 32'(bus.out_data), 32'h12);
`ifdef SEL_RANGE_CHECK_EN
        chk("after_oor_sel_err", 32'(bus.sel_err), 32'd0);
`endif
        tick();
        chk("after_oor_idle", 32'(bus.out_valid), 32'd0);

        // fill with 3 requests, then reset for one cycle
        bus.in_valid = 1'b1; bus.in_sel = 4'd1;
        tick();
        bus.in_sel = 4'd2;
        tick();
        bus.in_sel = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_data",     32'(bus.out_data), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // N=2, W=1 corner: one-cycle latency
        bus2.in_valid = 1'b1; bus2.in_sel = 1'b1;
        tick();
        chk("n2_valid", 32'(bus2.out_valid), 32'd1);
        chk("n2_sel1",  32'(bus2.out_data),  32'd1);
`ifdef SEL_RANGE_CHECK_EN
        chk("n2_sel_err", 32'(bus2.sel_err), 32'd0);
`endif
        bus2.in_sel = 1'b0;
        tick();
        chk("n2_sel0", 32'(bus2.out_data), 32'd0);
        bus2.in_valid = 1'b0;
        tick();
        chk("n2_idle", 32'(bus2.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised N:1 selector for W-bit channels, built as a binary tree of 2:1 stages.
- A pipeline register follows every tree level; a valid/ready handshake runs alongside the data.
- Generalises the fixed 12:1 single-bit mux to arbitrary channel count and width at full clock rate, with backpressure.
- Sits between multi-channel sample sources and a single downstream consumer.

Parameters:
- N, 12, number of input channels (N >= 2).
- W, 1, bits per channel.
- SW, $clog2(N), select width; also the tree depth L and the latency in cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_sel  input  SW  channel index, captured with in_valid.
- in_valid  input  1  request present this cycle.
- in_ready  output  1  request accepted when in_valid && in_ready.
- out_data  output  W  selected channel.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- sel_err  output  1  only with SEL_RANGE_CHECK_EN; aligned with out_data.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Tree structure:
  - Inputs are zero-padded to 2^L channels.
  - Level k (1..L) reduces pairs using select bit in_sel[k-1]; 0 picks the lower index.
  - Level k output is registered as stage k.
  - Each stage also registers: a valid bit, the still-unused upper select bits, and (with the macro) the error bit.
- Latency: exactly L cycles from acceptance to out_valid, when not stalled. For N=12, L=4.
- Throughput: one request per cycle. No combinational path from in_data or in_sel to out_data.
- Stall rule:
  - stall = out_valid && !out_ready.
  - While stall is high, every stage holds its data, select bits and valid; in_ready = !stall.
  - Pipeline bubbles are not collapsed; the whole pipe freezes as a unit.
- in_ready depends only on out_valid and out_ready. No dependence on in_valid.
- Accepting a request when in_valid is low writes valid=0 into stage 1; data in that stage is don't-care.
- Out-of-range select (in_sel >= N): result is 0 (padded channels). Not an error without the macro.
- Reset:
  - All stage valid bits clear; out_valid=0, out_data=0, sel_err=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight requests; none emerge afterwards.
- Simultaneous accept and drain in the same cycle: both occur, no loss and no duplication.
- out_data and out_valid stay stable while stalled, per valid/ready rules.

Optional Feature:
- Macro: SEL_RANGE_CHECK_EN.
- Defined:
  - sel_err = registered (in_sel >= N), pipelined with the request.
  - Asserted only with out_valid; forced 0 when out_valid=0.
  - out_data=0 for an erroneous request.
- Undefined: sel_err port and logic absent. Out-of-range select silently yields 0.
- When N is a power of two, the check is constant 0 but the port still exists.

Test Plan:
- N=12, W=8, channel c = 8'h10+c, out_ready=1. Send sel=0,5,11 on consecutive cycles -> out_valid on cycles 4,5,6 with 8'h10, 8'h15, 8'h1B; in_ready=1 throughout.
- Back-to-back stream of sel=0..11 with out_ready held 0 from the first out_valid for 3 cycles -> out_data frozen at 8'h10, in_ready=0 during the stall; afterwards all 12 values emerge in order, none lost or duplicated.
- Alternate in_valid 1/0 with sel=3 -> outputs 8'h13 on every other cycle; bubbles preserved, out_valid=0 between them.
- With SEL_RANGE_CHECK_EN, sel=13 -> after 4 cycles out_valid=1, sel_err=1, out_data=0. Then sel=2 -> sel_err=0, out_data=8'h12. Without the macro, sel=13 -> out_data=0.
- Fill the pipe with 3 requests, assert rst_n=0 for one cycle -> out_valid=0 the next cycle and stays 0 for 4+ idle cycles; in_ready=1.
- N=2, W=1 corner: L=1. sel=1 with in_data=2'b10 -> out_data=1 one cycle after acceptance.
